plugboard_pairs: RTL and testbench

//  Enigma plugboard (Steckerbrett) stage between the keyboard decoder and the rotor/reflector.
//  It takes one-hot letters from the decoder. In program mode, consecutive keystrokes are

---
 rtl/plugboard_pairs.sv | 121 ++++++++++++
 tb/tb_plugboard_pairs.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/plugboard_pairs.sv
// Enigma plugboard: records letter pairs while in program mode and swaps each
// one-hot letter with its stored partner in run mode, with a one-cycle registered result.
module plugboard_pairs #(
  parameter int MAX_PAIRS = 10,
  parameter int LETTERS   = 26
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [LETTERS-1:0] in_letter,
  input  logic               in_valid,
  input  logic               program_mode,
  input  logic               clear_pairs,
  output logic [LETTERS-1:0] out_letter,
  output logic               out_valid,
  output logic [3:0]         pair_count,
  output logic               pending,
  output logic               err
);

  localparam int IDX_W = $clog2(LETTERS);

  typedef enum logic {IDLE, HAVE_FIRST} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   map_q [LETTERS];
  logic [IDX_W-1:0]   first_q, first_d;
  logic [3:0]         count_q;
  logic [IDX_W:0]     dec;
  logic               letter_ok;
  logic [IDX_W-1:0]   idx;
  logic               wr_pair;
  logic               err_d;
  logic               out_vld_d;
  logic [LETTERS-1:0] out_d;

  // Returns {exactly_one_bit_set, index_of_that_bit}.
  function automatic logic [IDX_W:0] decode(input logic [LETTERS-1:0] v);
    int               n;
    logic [IDX_W-1:0] pos;
    n   = 0;
    pos = '0;
    for (int i = 0; i < LETTERS; i++) begin
      if (v[i]) begin
        n   = n + 1;
        pos = IDX_W'(i);
      end
    end
    return {(n == 1), pos};
  endfunction

  assign dec       = decode(in_letter);
  assign letter_ok = dec[IDX_W];
  assign idx       = dec[IDX_W-1:0];

  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    wr_pair   = 1'b0;
    err_d     = 1'b0;
    out_vld_d = 1'b0;
    out_d     = out_letter;
    // Leaving program mode drops any half-entered pair; the input is then handled as run mode.
    if (!program_mode) state_d = IDLE;
    if (in_valid) begin
      if (!letter_ok) begin
        err_d = 1'b1;
      end else if (!program_mode) begin
        out_vld_d = 1'b1;
        out_d     = LETTERS'(1) << map_q[idx];
      end else if (state_q == IDLE) begin
        if (map_q[idx] != idx || count_q == 4'(MAX_PAIRS)) begin
          err_d = 1'b1;
        end else begin
          first_d = idx;
          state_d = HAVE_FIRST;
        end
      end else begin
        if (idx == first_q || map_q[idx] != idx) err_d = 1'b1;
        else                                     wr_pair = 1'b1;
        state_d = IDLE;
      end
    end
  end

  // ---- register stage: control, partner table and output ----
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      out_letter <= '0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
      for (int i = 0; i < LETTERS; i++) map_q[i] <= IDX_W'(i);
    end else if (clear_pairs) begin
      state_q   <= IDLE;
      count_q   <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < LETTERS; i++) map_q[i] <= IDX_W'(i);
    end else begin
      state_q    <= state_d;
      out_letter <= out_d;
      out_valid  <= out_vld_d;
      err        <= err_d;
      if (wr_pair) begin
        map_q[first_q] <= idx;
        map_q[idx]     <= first_q;
        count_q        <= count_q + 4'd1;
      end
    end
  end

  // Held first letter is only meaningful while pending, so it needs no reset.
  always_ff @(posedge CLOCK_50) begin
    first_q <= first_d;
  end

  assign pair_count = count_q;
  assign pending    = (state_q == HAVE_FIRST);

endmodule

// File: tb/tb_plugboard_pairs.sv
// Bench for plugboard_pairs: a pair-list model checked every cycle, plus directed
// literal expectations for the plugboard scenarios.
module tb_plugboard_pairs;

  localparam int MAX_PAIRS = 10;
  localparam int LETTERS   = 26;

  logic               clk;
  logic               reset;
  logic [LETTERS-1:0] in_letter;
  logic               in_valid;
  logic               program_mode;
  logic               clear_pairs;
  logic [LETTERS-1:0] out_letter;
  logic               out_valid;
  logic [3:0]         pair_count;
  logic               pending;
  logic               err;

  int errors = 0;
  int checks = 0;

  plugboard_pairs #(.MAX_PAIRS(MAX_PAIRS), .LETTERS(LETTERS)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .in_letter   (in_letter),
    .in_valid    (in_valid),
    .program_mode(program_mode),
    .clear_pairs (clear_pairs),
    .out_letter  (out_letter),
    .out_valid   (out_valid),
    .pair_count  (pair_count),
    .pending     (pending),
    .err         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: list of stored pairs ----------------
  int                 pa[$];
  int                 pb[$];
  bit                 m_have_first;
  int                 m_first;
  logic [LETTERS-1:0] m_out;
  bit                 m_out_valid;
  bit                 m_err;
  bit                 live = 0;

  function automatic int partner(input int x);
    foreach (pa[k]) begin
      if (pa[k] == x) return pb[k];
      if (pb[k] == x) return pa[k];
    end
    return x;
  endfunction

  always @(posedge clk) begin
    int idx;
    m_out_valid = 0;
    m_err       = 0;
    if (reset) begin
      pa.delete(); pb.delete();
      m_have_first = 0;
      m_out        = '0;
      live         = 1;
    end else if (clear_pairs) begin
      pa.delete(); pb.delete();
      m_have_first = 0;
    end else begin
      if (!program_mode) m_have_first = 0;
      if (in_valid) begin
        if ($countones(in_letter) != 1) begin
          m_err = 1;
        end else begin
          idx = 0;
          for (int i = 0; i < LETTERS; i++) if (in_letter[i]) idx = i;
          if (!program_mode) begin
            m_out_valid = 1;
            m_out       = '0;
            m_out[partner(idx)] = 1'b1;
          end else if (!m_have_first) begin
            if (partner(idx) != idx || pa.size() == MAX_PAIRS) m_err = 1;
            else begin
              m_first      = idx;
              m_have_first = 1;
            end
          end else begin
            if (idx == m_first || partner(idx) != idx) m_err = 1;
            else begin
              pa.push_back(m_first);
              pb.push_back(idx);
            end
            m_have_first = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (live) begin
      chk("out_valid", 32'(out_valid), 32'(m_out_valid));
      chk("err", 32'(err), 32'(m_err));
      chk("pending", 32'(pending), 32'(m_have_first));
      chk("pair_count", 32'(pair_count), 32'(pa.size()));
      chk("out_letter", 32'(out_letter), 32'(m_out));
      chk("err_and_valid", 32'(err & out_valid), 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [LETTERS-1:0] L(input int i);
    logic [LETTERS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic cyc(input logic [LETTERS-1:0] l, input logic v, input logic pm,
                     input logic clr, input logic rst);
    in_letter    = l;
    in_valid     = v;
    program_mode = pm;
    clear_pairs  = clr;
    reset        = rst;
    @(posedge clk);
    #2;
  endtask

  task automatic key(input logic pm, input int i);
    cyc(L(i), 1'b1, pm, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic pm);
    cyc('0, 1'b0, pm, 1'b0, 1'b0);
  endtask

  task automatic run_all();
    for (int i = 0; i < LETTERS; i++) key(1'b0, i);
    idle(1'b0);
  endtask

  initial begin
    in_letter = '0; in_valid = 0; program_mode = 0; clear_pairs = 0; reset = 1;

    // 1: reset state and pass-through of A
    cyc('0, 0, 0, 0, 1);
    cyc('0, 0, 0, 0, 1);
    chk("rst_count", 32'(pair_count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_letter", 32'(out_letter), 0);
    key(0, 0);
    chk("t1_letter", 32'(out_letter), 32'h1);
    chk("t1_valid", 32'(out_valid), 1);
    idle(0);
    chk("t1_one_cycle", 32'(out_valid), 0);
    chk("t1_hold", 32'(out_letter), 32'h1);

    // 2: A<->Z
    key(1, 0);
    chk("t2_pending", 32'(pending), 1);
    key(1, 25);
    chk("t2_count", 32'(pair_count), 1);
    chk("t2_pending0", 32'(pending), 0);
    idle(0);
    key(0, 0);
    chk("t2_a2z", 32'(out_letter), 32'h2000000);
    key(0, 25);
    chk("t2_z2a", 32'(out_letter), 32'h1);
    chk("t2_b2b_valid", 32'(out_valid), 1);
    key(0, 1);
    chk("t2_b", 32'(out_letter), 32'h2);
    idle(0);

    // 4: rejections
    key(1, 0);
    chk("t4_paired_first", 32'(err), 1);
    chk("t4_paired_pend", 32'(pending), 0);
    key(1, 3);
    key(1, 3);
    chk("t4_same_err", 32'(err), 1);
    chk("t4_same_pend", 32'(pending), 0);
    key(1, 2);
    key(1, 0);
    chk("t4_second_paired", 32'(err), 1);
    chk("t4_count", 32'(pair_count), 1);
    cyc(26'h3, 1, 0, 0, 0);
    chk("t4_multi_err", 32'(err), 1);
    chk("t4_multi_novalid", 32'(out_valid), 0);
    cyc(26'h0, 1, 0, 0, 0);
    chk("t4_zero_err", 32'(err), 1);
    key(1, 4);
    cyc(26'h0, 1, 1, 0, 0);
    chk("t4_bad_keeps_pend", 32'(pending), 1);
    idle(0);
    run_all();

    // 3: fill to MAX_PAIRS
    cyc('0, 0, 0, 1, 0);
    chk("t3_clear", 32'(pair_count), 0);
    for (int i = 0; i < MAX_PAIRS; i++) begin
      key(1, 2 * i);
      key(1, 2 * i + 1);
    end
    chk("t3_full", 32'(pair_count), 10);
    key(1, 20);
    chk("t3_over_err", 32'(err), 1);
    chk("t3_over_pend", 32'(pending), 0);
    chk("t3_over_count", 32'(pair_count), 10);
    idle(0);
    key(0, 19);
    chk("t3_t2s", 32'(out_letter), 32'h40000);
    run_all();

    // 5: mode drop discards held letter; clear with in_valid
    cyc('0, 0, 0, 1, 0);
    key(1, 1);
    chk("t5_pend", 32'(pending), 1);
    key(0, 1);
    chk("t5_drop_pend", 32'(pending), 0);
    chk("t5_drop_out", 32'(out_letter), 32'h2);
    chk("t5_drop_valid", 32'(out_valid), 1);
    key(1, 1);
    idle(0);
    chk("t5_count0", 32'(pair_count), 0);
    key(1, 0);
    key(1, 25);
    cyc(L(0), 1, 0, 1, 0);
    chk("t5_clr_count", 32'(pair_count), 0);
    chk("t5_clr_novalid", 32'(out_valid), 0);
    run_all();

    // 6: reset while pending with 3 pairs
    key(1, 5); key(1, 6);
    key(1, 7); key(1, 8);
    key(1, 9); key(1, 12);
    key(1, 10);
    chk("t6_pre_count", 32'(pair_count), 3);
    chk("t6_pre_pend", 32'(pending), 1);
    cyc(L(11), 1, 1, 0, 1);
    chk("t6_count", 32'(pair_count), 0);
    chk("t6_pend", 32'(pending), 0);
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_letter", 32'(out_letter), 0);
    run_all();
    key(0, 5);
    chk("t6_identity", 32'(out_letter), 32'h20);
    idle(0);
    idle(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
